// File: rtl/pipe_buf_pkg.sv
// Shared encodings and helpers for the multi-entry elastic pipeline buffer.
package pipe_buf_pkg;

   localparam int READY_REG  = 0;
   localparam int READY_PASS = 1;

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_width(input int entries);
      return (entries <= 2) ? 1 : $clog2(entries);
   endfunction

   // Explicit compare so non-power-of-two entry counts wrap correctly.
   function automatic int ptr_next(input int ptr, input int last);
      return (ptr == last) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/pipe_buf_storage.sv
// Circular register array behind the output register; combinational read of the oldest entry.
module pipe_buf_storage import pipe_buf_pkg::*; #(
   parameter int DWIDTH  = 8,
   parameter int ENTRIES = 3,
   parameter int PWIDTH  = ptr_width(ENTRIES)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DWIDTH-1:0] wr_data,
   input  logic              rd_en,
   output logic [DWIDTH-1:0] rd_data
);

   logic [DWIDTH-1:0] mem [ENTRIES];
   logic [PWIDTH-1:0] wr_ptr;
   logic [PWIDTH-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= PWIDTH'(ptr_next(int'(wr_ptr), ENTRIES - 1));
         if (rd_en) rd_ptr <= PWIDTH'(ptr_next(int'(rd_ptr), ENTRIES - 1));
      end
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/pipe_elastic_buffer.sv
// Multi-entry valid/ready elastic stage: registered output head plus circular storage,
// occupancy count, synchronous flush and selectable registered/pass-through upstream ready.
module pipe_elastic_buffer import pipe_buf_pkg::*; #(
   parameter int DWIDTH     = 8,
   parameter int DEPTH      = 4,
   parameter int READY_MODE = READY_REG,
   parameter int CWIDTH     = cnt_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [DWIDTH-1:0] i_data,
   input  logic              i_valid,
   output logic              o_ready,
   output logic [DWIDTH-1:0] o_data,
   output logic              o_valid,
   input  logic              i_ready,
   input  logic              i_flush,
   output logic [CWIDTH-1:0] o_count
);

   // Handshake: a word moves on a rising edge where valid && ready on that side;
   // once valid is raised the sender holds data/valid steady until that edge.

   logic [CWIDTH-1:0] count;
   logic [CWIDTH-1:0] count_nx;
   logic              push;
   logic              pop;
   logic              full;
   logic              ready_q;
   logic              head_load;
   logic              st_empty;
   logic              st_wr;
   logic              st_rd;
   logic [DWIDTH-1:0] st_rd_data;

   assign full      = (count == CWIDTH'(DEPTH));
   assign o_ready   = (READY_MODE == READY_PASS) ? (!full || i_ready) : ready_q;
   assign push      = i_valid && o_ready;
   assign pop       = o_valid && i_ready;
   assign head_load = !o_valid || pop;
   // Head register holds one word whenever count is non-zero, so storage is empty at count<=1.
   assign st_empty  = (count <= CWIDTH'(1));
   assign st_rd     = head_load && !st_empty && !i_flush;
   assign st_wr     = push && !(head_load && st_empty) && !i_flush;
   assign count_nx  = i_flush ? '0 : (count + CWIDTH'(push) - CWIDTH'(pop));
   assign o_count   = count;

   pipe_buf_storage #(
      .DWIDTH  (DWIDTH),
      .ENTRIES (DEPTH - 1)
   ) u_storage (
      .clk     (clk),
      .rstn    (rstn),
      .flush   (i_flush),
      .wr_en   (st_wr),
      .wr_data (i_data),
      .rd_en   (st_rd),
      .rd_data (st_rd_data)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count   <= '0;
         ready_q <= 1'b0;
         o_valid <= 1'b0;
         o_data  <= '0;
      end else begin
         count   <= count_nx;
         ready_q <= (count_nx != CWIDTH'(DEPTH));
         if (i_flush) begin
            o_valid <= 1'b0;
         end else if (head_load) begin
            // Refill from storage first to keep order; bypass input only when storage is empty.
            if (!st_empty) begin
               o_data  <= st_rd_data;
               o_valid <= 1'b1;
            end else if (push) begin
               o_data  <= i_data;
               o_valid <= 1'b1;
            end else begin
               o_valid <= 1'b0;
            end
         end
      end
   end

   a_count_bound: assert property (@(posedge clk) disable iff (!rstn) count <= CWIDTH'(DEPTH));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rstn) !(pop && count == '0));

endmodule
